// File: rtl/score_collector.sv
// Assembles a stream of per-class scores into one N-lane frame held for the argmax stage.
// Optional SCORE_SYNC_EN adds in_first resynchronisation and a sync_err pulse.
module score_collector #(
  parameter int N    = 10,
  parameter int W    = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
`ifdef SCORE_SYNC_EN
  input  logic            in_first,
  output logic            sync_err,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_scores,
  output logic [15:0]     frame_cnt,
  output logic [CNTW-1:0] lane_idx
);

  localparam logic [CNTW-1:0] LAST_LANE = CNTW'(N - 1);

  logic [CNTW-1:0]    lane_q, lane_d;
  logic [(N-1)*W-1:0] buf_q, buf_d;
  logic [N*W-1:0]     out_scores_q, out_scores_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               at_last, accept, take, load, first_beat;

  assign at_last  = (lane_q == LAST_LANE);
  // Only the last lane waits on the output side; earlier lanes never stall.
  assign in_ready = !rst && (!at_last || !out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = out_valid_q && out_ready;

`ifdef SCORE_SYNC_EN
  logic sync_err_q, sync_err_d;
  assign first_beat = accept && in_first;
  assign sync_err_d = first_beat && (lane_q != '0);
  assign sync_err   = sync_err_q;
`else
  assign first_beat = 1'b0;
`endif

  assign load = accept && at_last && !first_beat;

  always_comb begin
    lane_d = lane_q;
    buf_d  = buf_q;
    if (first_beat) begin
      buf_d[W-1:0] = in_data;
      lane_d       = CNTW'(1);
    end else if (accept) begin
      if (at_last) begin
        lane_d = '0;
      end else begin
        for (int k = 0; k < N - 1; k++) begin
          if (lane_q == CNTW'(k)) buf_d[k*W +: W] = in_data;
        end
        lane_d = lane_q + CNTW'(1);
      end
    end
  end

  // A load on the same edge as a take keeps out_valid high with the new frame.
  assign out_valid_d  = load || (out_valid_q && !out_ready);
  assign out_scores_d = load ? {in_data, buf_q} : out_scores_q;
  assign frame_cnt_d  = frame_cnt_q + 16'(take);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q       <= '0;
      buf_q        <= '0;
      out_scores_q <= '0;
      out_valid_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      out_scores_q <= out_scores_d;
      out_valid_q  <= out_valid_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

`ifdef SCORE_SYNC_EN
  always_ff @(posedge clk) begin
    if (rst) sync_err_q <= 1'b0;
    else     sync_err_q <= sync_err_d;
  end
`endif

  assign out_valid  = out_valid_q;
  assign out_scores = out_scores_q;
  assign frame_cnt  = frame_cnt_q;
  assign lane_idx   = lane_q;

endmodule

// File: tb/tb_score_collector.sv
// Bench for score_collector: queue-based frame model checked every cycle, plus directed literals.
module tb_score_collector;
  localparam int N    = 10;
  localparam int W    = 8;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            in_first = 1'b0;
  logic            sync_err_w;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N*W-1:0]  out_scores;
  logic [15:0]     frame_cnt;
  logic [CNTW-1:0] lane_idx;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  score_collector #(.N(N), .W(W), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef SCORE_SYNC_EN
    .in_first   (in_first),
    .sync_err   (sync_err_w),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_scores (out_scores),
    .frame_cnt  (frame_cnt),
    .lane_idx   (lane_idx)
  );

`ifndef SCORE_SYNC_EN
  assign sync_err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: scores accepted so far in the current frame, plus the frame on offer.
  logic [7:0]  cur[$];
  logic [7:0]  exp_lane[N];
  bit          exp_valid = 1'b0;
  int unsigned exp_cnt = 0;
  int unsigned cnt_bias = 0;
  bit          exp_serr = 1'b0;

  function automatic bit model_ready();
    return !rst && ((cur.size() != N - 1) || !exp_valid || out_ready);
  endfunction

  initial forever begin
    bit rdy, tk, ld;
    @(posedge clk);
    if (rst) begin
      cur.delete();
      foreach (exp_lane[k]) exp_lane[k] = 8'h00;
      exp_valid = 1'b0;
      exp_cnt   = 0;
      exp_serr  = 1'b0;
    end else begin
      rdy = model_ready();
      tk  = exp_valid && out_ready;
      ld  = 1'b0;
      exp_serr = 1'b0;
      if (in_valid && rdy) begin
`ifdef SCORE_SYNC_EN
        if (in_first) begin
          exp_serr = (cur.size() != 0);
          cur.delete();
          cur.push_back(in_data);
        end else
`endif
        begin
          cur.push_back(in_data);
          if (cur.size() == N) begin
            foreach (exp_lane[k]) exp_lane[k] = cur[k];
            cur.delete();
            ld = 1'b1;
          end
        end
      end
      if (tk) exp_cnt++;
      if (ld) exp_valid = 1'b1;
      else if (tk) exp_valid = 1'b0;
    end
  end

  initial forever begin
    logic [N*W-1:0] ev;
    @(negedge clk);
    if (chk_en) begin
      foreach (exp_lane[k]) ev[k*W +: W] = exp_lane[k];
      check("in_ready",   {127'd0, in_ready},  {127'd0, model_ready()});
      check("out_valid",  {127'd0, out_valid}, {127'd0, exp_valid});
      check("out_scores", {48'd0, out_scores}, {48'd0, ev});
      check("frame_cnt",  {112'd0, frame_cnt}, {112'd0, 16'(exp_cnt + cnt_bias)});
      check("lane_idx",   {124'd0, lane_idx},  {124'd0, CNTW'(cur.size())});
`ifdef SCORE_SYNC_EN
      check("sync_err",   {127'd0, sync_err_w}, {127'd0, exp_serr});
`endif
    end
  end

  // All drivers assume they start 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] d, input bit first);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = first;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 60) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_timeout: got no accept after %0d cycles expected accept", n);
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic frame(input logic [7:0] base);
    for (int k = 0; k < N; k++) beat(base + 8'(k), 1'b0);
  endtask

  initial begin
    logic [15:0] cnt0;
    // Reset
    @(posedge clk);
    #1 chk_en = 1'b1;
    idle(2);
    @(negedge clk);
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_lane", {124'd0, lane_idx}, 128'd0);
    check("post_rst_cnt", {112'd0, frame_cnt}, 128'd0);
    @(posedge clk);
    #1;

    // Test 1: single frame, consumer always ready
    out_ready = 1'b1;
    frame(8'h10);
    @(negedge clk);
    check("t1_valid", {127'd0, out_valid}, 128'd1);
    check("t1_scores", {48'd0, out_scores}, {48'd0, 80'h19181716151413121110});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_cnt", {112'd0, frame_cnt}, 128'd1);
    check("t1_valid_drop", {127'd0, out_valid}, 128'd0);
    @(posedge clk);
    #1;

    // Test 2: back-to-back frames with the consumer stalled
    out_ready = 1'b0;
    fork
      begin
        frame(8'h20);
        frame(8'h30);
      end
      begin
        idle(25);
        @(negedge clk);
        check("t2_stall_ready", {127'd0, in_ready}, 128'd0);
        check("t2_stall_lane", {124'd0, lane_idx}, 128'd9);
        check("t2_held", {48'd0, out_scores}, {48'd0, 80'h29282726252423222120});
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    @(negedge clk);
    check("t2_f2_valid", {127'd0, out_valid}, 128'd1);
    check("t2_f2", {48'd0, out_scores}, {48'd0, 80'h39383736353433323130});
    check("t2_cnt", {112'd0, frame_cnt}, 128'd2);
    @(posedge clk);
    #1;
    idle(2);
    check("t2_cnt_after", {112'd0, frame_cnt}, 128'd3);

    // Test 3: random idle gaps across three random frames
    for (int i = 0; i < 3 * N; i++) begin
      if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
      beat(8'($urandom_range(0, 255)), 1'b0);
    end
    idle(3);

    // Test 4: reset mid-frame discards the partial frame
    for (int k = 0; k < 5; k++) beat(8'h50 + 8'(k), 1'b0);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    check("t4_rst_valid", {127'd0, out_valid}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    frame(8'hA0);
    @(negedge clk);
    check("t4_scores", {48'd0, out_scores}, {48'd0, 80'hA9A8A7A6A5A4A3A2A1A0});
    @(posedge clk);
    #1;
    idle(2);

`ifdef SCORE_SYNC_EN
    // Test 5: in_first mid-frame restarts framing
    cnt0 = frame_cnt;
    for (int k = 0; k < 4; k++) beat(8'h01 + 8'(k), 1'b0);
    beat(8'h55, 1'b1);
    for (int k = 0; k < N - 1; k++) beat(8'h61 + 8'(k), 1'b0);
    @(negedge clk);
    check("t5_scores", {48'd0, out_scores}, {48'd0, 80'h69686766656463626155});
    @(posedge clk);
    #1;
    idle(2);
    check("t5_one_frame", {112'd0, frame_cnt}, {112'd0, cnt0 + 16'd1});
`endif

    // Test 6: counter wrap via a preset shortcut
    cnt_bias = 32'h0000FFFE - exp_cnt;
    force dut.frame_cnt_q = 16'hFFFE;
    #1 release dut.frame_cnt_q;
    @(posedge clk);
    #1;
    frame(8'hC0);
    idle(2);
    check("t6_cnt_ffff", {112'd0, frame_cnt}, {112'd0, 16'hFFFF});
    frame(8'hD0);
    idle(2);
    @(negedge clk);
    check("t6_cnt_wrap", {112'd0, frame_cnt}, 128'd0);
    check("t6_scores", {48'd0, out_scores}, {48'd0, 80'hD9D8D7D6D5D4D3D2D1D0});
    @(posedge clk);
    #1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
